// File: rtl/hssl_link_sequencer_if.sv
// Transceiver-side reset/status bundle between the link sequencer and the transceiver wrapper.
// The master modport is the sequencer; the slave modport is the transceiver wrapper.
interface hssl_link_sequencer_if;
    logic tx_usrclk_active_in;
    logic tx_reset_done_in;
    logic rx_reset_done_in;
    logic rx_aligned_in;
    logic reset_all_out;
    logic tx_reset_datapath_out;
    logic rx_reset_datapath_out;
    logic tx_elecidle_out;

    modport master (
        input  tx_usrclk_active_in,
        input  tx_reset_done_in,
        input  rx_reset_done_in,
        input  rx_aligned_in,
        output reset_all_out,
        output tx_reset_datapath_out,
        output rx_reset_datapath_out,
        output tx_elecidle_out
    );

    modport slave (
        output tx_usrclk_active_in,
        output tx_reset_done_in,
        output rx_reset_done_in,
        output rx_aligned_in,
        input  reset_all_out,
        input  tx_reset_datapath_out,
        input  rx_reset_datapath_out,
        input  tx_elecidle_out
    );
endinterface

// File: rtl/hssl_link_sequencer.sv
// HSSL transceiver bring-up/recovery sequencer: reset, wait for done/align, link up, retry or fault.
// Define HSSL_SEQ_AUTO_RECOVER_EN to recover from link loss via datapath resets instead of FAULT.
module hssl_link_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned ALIGN_CYCLES   = 256,
    parameter int unsigned MAX_RETRIES    = 7
) (
    input  logic                  freerun_clk_in,
    input  logic                  reset_n_in,
    input  logic                  restart_in,
    hssl_link_sequencer_if.master xcvr,
    output logic                  link_up_out,
    output logic                  fault_out,
    output logic [7:0]            retry_cnt_out,
    output logic [3:0]            state_out
);

    localparam int unsigned CntMax = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES
                                                                     : RESET_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned AlignW = $clog2(ALIGN_CYCLES + 1);

    localparam logic [CntW-1:0]   ResetLast   = CntW'(RESET_CYCLES - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [AlignW-1:0] AlignDone   = AlignW'(ALIGN_CYCLES);
    localparam logic [7:0]        RetryMax    = 8'(MAX_RETRIES);

    typedef enum logic [3:0] {
        StResetAll   = 4'd0,
        StWaitTxClk  = 4'd1,
        StWaitTxDone = 4'd2,
        StWaitRxDone = 4'd3,
        StWaitAlign  = 4'd4,
        StLinkUp     = 4'd5,
        StTxReset    = 4'd6,
        StRxReset    = 4'd7,
        StBackoff    = 4'd8,
        StFault      = 4'd9
    } state_e;

    logic [3:0] sync1_q, sync2_q;
    logic       tx_clk_ok, tx_done_ok, rx_done_ok, aligned_ok;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AlignW-1:0] align_q, align_d, align_inc;
    logic [7:0]        retry_q, retry_d;
    logic              timeout;
    logic              reset_all_q, tx_dp_q, rx_dp_q, elecidle_q, link_up_q, fault_q;

    assign {aligned_ok, rx_done_ok, tx_done_ok, tx_clk_ok} = sync2_q;

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        align_d   = '0;
        timeout   = (cnt_q == TimeoutLast);
        align_inc = aligned_ok ? (align_q + AlignW'(1)) : '0;
        unique case (state_q)
            StResetAll: begin
                if (cnt_q == ResetLast) state_d = StWaitTxClk;
            end
            StWaitTxClk: begin
                if (tx_clk_ok)    state_d = StWaitTxDone;
                else if (timeout) state_d = StBackoff;
            end
            StWaitTxDone: begin
                if (tx_done_ok)   state_d = StWaitRxDone;
                else if (timeout) state_d = StBackoff;
            end
            StWaitRxDone: begin
                if (rx_done_ok)   state_d = StWaitAlign;
                else if (timeout) state_d = StBackoff;
            end
            StWaitAlign: begin
                align_d = align_inc;
                if (align_inc == AlignDone) state_d = StLinkUp;
                else if (timeout)           state_d = StBackoff;
            end
            StLinkUp: begin
`ifdef HSSL_SEQ_AUTO_RECOVER_EN
                if (!tx_done_ok)                      state_d = StTxReset;
                else if (!rx_done_ok || !aligned_ok)  state_d = StRxReset;
`else
                if (!tx_done_ok || !rx_done_ok || !aligned_ok) state_d = StFault;
`endif
            end
`ifdef HSSL_SEQ_AUTO_RECOVER_EN
            StTxReset: begin
                if (cnt_q == ResetLast) state_d = StWaitTxDone;
            end
            StRxReset: begin
                if (cnt_q == ResetLast) state_d = StWaitRxDone;
            end
`endif
            StBackoff: begin
                retry_d = (retry_q == 8'hFF) ? retry_q : (retry_q + 8'd1);
                state_d = (retry_d >= RetryMax) ? StFault : StResetAll;
            end
            StFault: begin
                if (restart_in) begin
                    retry_d = '0;
                    state_d = StResetAll;
                end
            end
            default: state_d = StResetAll;
        endcase
        // Dwell counter restarts on every state change
        cnt_d = (state_d != state_q) ? '0 : (cnt_q + CntW'(1));
    end

    always_ff @(posedge freerun_clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= StResetAll;
            cnt_q       <= '0;
            align_q     <= '0;
            retry_q     <= '0;
            reset_all_q <= 1'b1;
            tx_dp_q     <= 1'b0;
            rx_dp_q     <= 1'b0;
            elecidle_q  <= 1'b1;
            link_up_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            sync1_q     <= {xcvr.rx_aligned_in, xcvr.rx_reset_done_in,
                            xcvr.tx_reset_done_in, xcvr.tx_usrclk_active_in};
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            align_q     <= align_d;
            retry_q     <= retry_d;
            reset_all_q <= (state_d == StResetAll);
            tx_dp_q     <= (state_d == StTxReset);
            rx_dp_q     <= (state_d == StRxReset);
            elecidle_q  <= (state_d inside {StResetAll, StWaitTxClk, StWaitTxDone, StTxReset,
                                            StFault, StBackoff});
            link_up_q   <= (state_d == StLinkUp);
            fault_q     <= (state_d == StFault);
        end
    end

    assign xcvr.reset_all_out         = reset_all_q;
    assign xcvr.tx_reset_datapath_out = tx_dp_q;
    assign xcvr.rx_reset_datapath_out = rx_dp_q;
    assign xcvr.tx_elecidle_out       = elecidle_q;
    assign link_up_out                = link_up_q;
    assign fault_out                  = fault_q;
    assign retry_cnt_out              = retry_q;
    assign state_out                  = state_q;

endmodule

// File: tb/tb_hssl_link_sequencer.sv
// Self-checking bench for hssl_link_sequencer: directed bring-up, loss handling, randomized
// align glitches and randomized stuck-input timeouts against arithmetic timing expectations.
module tb_hssl_link_sequencer;

    localparam int unsigned RC = 4;
    localparam int unsigned TC = 64;
    localparam int unsigned AC = 8;
    localparam int unsigned MR = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       restart = 1'b0;
    logic       link_up, fault;
    logic [7:0] retry;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    hssl_link_sequencer_if xif ();

    hssl_link_sequencer #(
        .RESET_CYCLES  (RC),
        .TIMEOUT_CYCLES(TC),
        .ALIGN_CYCLES  (AC),
        .MAX_RETRIES   (MR)
    ) dut (
        .freerun_clk_in(clk),
        .reset_n_in    (rst_n),
        .restart_in    (restart),
        .xcvr          (xif),
        .link_up_out   (link_up),
        .fault_out     (fault),
        .retry_cnt_out (retry),
        .state_out     (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input string tag, input int s, input int budget, output int n);
        n = 0;
        while (int'(state) != s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic set_inputs(input logic usr, input logic txd, input logic rxd, input logic al);
        xif.tx_usrclk_active_in = usr;
        xif.tx_reset_done_in    = txd;
        xif.rx_reset_done_in    = rxd;
        xif.rx_aligned_in       = al;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 0);
        chk({tag, "_reset_all"}, 32'(xif.reset_all_out), 1);
        chk({tag, "_tx_dp"}, 32'(xif.tx_reset_datapath_out), 0);
        chk({tag, "_rx_dp"}, 32'(xif.rx_reset_datapath_out), 0);
        chk({tag, "_elecidle"}, 32'(xif.tx_elecidle_out), 1);
        chk({tag, "_link_up"}, 32'(link_up), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_retry"}, 32'(retry), 0);
    endtask

    task automatic do_reset(input logic usr, input logic txd, input logic rxd, input logic al);
        rst_n = 1'b0;
        set_inputs(usr, txd, rxd, al);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g;
        int len;
        int k;
        logic dp_seen;

        set_inputs(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) tick();
        check_reset_vals("in_reset");

        // Nominal bring-up
        do_reset(1'b1, 1'b1, 1'b1, 1'b1);
        n = 0;
        while (xif.reset_all_out && n < 20) begin
            tick();
            n++;
        end
        chk("reset_all_width", 32'(n), RC);
        chk("nom_state1", 32'(state), 1);
        tick(); chk("nom_state2", 32'(state), 2);
        tick(); chk("nom_state3", 32'(state), 3);
        tick(); chk("nom_state4", 32'(state), 4);
        n = 0;
        while (!link_up && n < 40) begin
            tick();
            n++;
        end
        chk("nom_align_dwell", 32'(n), AC);
        chk("nom_state5", 32'(state), 5);
        chk("nom_elecidle", 32'(xif.tx_elecidle_out), 0);
        chk("nom_retry", 32'(retry), 0);
        chk("nom_reset_all", 32'(xif.reset_all_out), 0);

        // Loss of alignment in LINK_UP
        xif.rx_aligned_in = 1'b0;
        n = 0;
        dp_seen = 1'b0;
        while (state == 4'd5 && n < 10) begin
            tick();
            n++;
            dp_seen = dp_seen | xif.tx_reset_datapath_out | xif.rx_reset_datapath_out;
        end
        chk("loss_latency", 32'(n), 3);
        chk("loss_link_up", 32'(link_up), 0);
`ifdef HSSL_SEQ_AUTO_RECOVER_EN
        chk("loss_state", 32'(state), 7);
        chk("loss_rx_dp", 32'(xif.rx_reset_datapath_out), 1);
        chk("loss_elecidle", 32'(xif.tx_elecidle_out), 0);
        xif.rx_aligned_in = 1'b1;
        n = 0;
        while (xif.rx_reset_datapath_out && n < 20) begin
            tick();
            n++;
        end
        chk("rx_dp_width", 32'(n), RC);
        chk("relink_state3", 32'(state), 3);
        tick(); chk("relink_state4", 32'(state), 4);
        wait_state("relink_state5", 5, 40, n);
        chk("relink_dwell", 32'(n), AC);
        chk("relink_retry", 32'(retry), 0);

        // TX loss takes priority over RX loss
        xif.tx_reset_done_in = 1'b0;
        xif.rx_aligned_in    = 1'b0;
        n = 0;
        while (state == 4'd5 && n < 10) begin
            tick();
            n++;
        end
        chk("txloss_latency", 32'(n), 3);
        chk("txloss_state", 32'(state), 6);
        chk("txloss_tx_dp", 32'(xif.tx_reset_datapath_out), 1);
        chk("txloss_rx_dp", 32'(xif.rx_reset_datapath_out), 0);
        chk("txloss_elecidle", 32'(xif.tx_elecidle_out), 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_in_tx_reset");
`else
        chk("loss_state", 32'(state), 9);
        chk("loss_fault", 32'(fault), 1);
        chk("loss_retry", 32'(retry), 0);
        chk("loss_elecidle", 32'(xif.tx_elecidle_out), 1);
        repeat (4) begin
            tick();
            dp_seen = dp_seen | xif.tx_reset_datapath_out | xif.rx_reset_datapath_out;
        end
        chk("loss_no_dp_pulse", 32'(dp_seen), 0);
        chk("loss_fault_hold", 32'(state), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_in_fault");
`endif

        // Alignment glitches: first the fixed 5-clock case, then random position and length
        for (int it = 0; it < 4; it++) begin
            g   = (it == 0) ? 5 : int'($urandom_range(0, AC - 3));
            len = (it == 0) ? 1 : int'($urandom_range(1, 3));
            do_reset(1'b1, 1'b1, 1'b1, 1'b1);
            wait_state("glitch_enter_align", 4, 30, n);
            chk("glitch_entry_time", 32'(n), RC + 3);
            repeat (g) tick();
            xif.rx_aligned_in = 1'b0;
            repeat (len) tick();
            xif.rx_aligned_in = 1'b1;
            chk("glitch_no_early_link", 32'(link_up), 0);
            n = g + len;
            while (!link_up && n < 60) begin
                tick();
                n++;
            end
            // low seen after 2-flop sync + 1; count restarts once high is seen again
            chk("glitch_link_time", 32'(n), 32'(g + len + 2 + int'(AC)));
            chk("glitch_state5", 32'(state), 5);
        end

        // Timeouts with one randomly chosen stuck input
        k = int'($urandom_range(0, 2));
        do_reset(k != 0, k != 1, k != 2, 1'b1);
        for (int i = 1; i <= int'(MR); i++) begin
            wait_state("to_backoff", 8, 300, n);
            chk("to_backoff_time", 32'(n), 32'(int'(RC) + k + int'(TC)));
            chk("to_backoff_elecidle", 32'(xif.tx_elecidle_out), 1);
            tick();
            chk("to_retry", 32'(retry), 32'(i));
            if (i < int'(MR)) begin
                chk("to_retry_state", 32'(state), 0);
            end else begin
                chk("to_fault_state", 32'(state), 9);
                chk("to_fault_out", 32'(fault), 1);
            end
        end
        repeat (5) tick();
        chk("fault_hold", 32'(state), 9);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_state", 32'(state), 0);
        chk("restart_retry", 32'(retry), 0);
        chk("restart_fault", 32'(fault), 0);
        chk("restart_reset_all", 32'(xif.reset_all_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hssl_link_sequencer.md
# hssl_link_sequencer

Bring-up and recovery controller for the HSSL gigabit transceiver block. Runs on the free-running clock and sequences the transceiver's reset ports: full reset, TX user-clock/reset completion, RX reset completion, and comma alignment. It then declares the link up, watches for loss of link, and retries or faults. Sits between the top-level control/status logic and the transceiver wrapper's reset, done and electrical-idle ports.

## Interface
Parameters:
- RESET_CYCLES, 16: width in clocks of every reset pulse driven (reset_all_out, tx/rx datapath resets); ≥1.
- TIMEOUT_CYCLES, 65536: maximum clocks spent in any WAIT_* state before a retry.
- ALIGN_CYCLES, 256: consecutive synchronized clocks rx_aligned_in must be high before link up; 1 ≤ ALIGN_CYCLES < TIMEOUT_CYCLES.
- MAX_RETRIES, 7: failed bring-ups tolerated before FAULT; 1..255.

Ports:
- freerun_clk_in  input  1  free-running clock; sole clock of the block.
- reset_n_in  input  1  asynchronous, active-low reset.
- restart_in  input  1  synchronous pulse; leaves FAULT (ignored elsewhere).
- tx_usrclk_active_in  input  1  transceiver TX user clock active (async, synchronized internally).
- tx_reset_done_in  input  1  TX reset done (async, synchronized).
- rx_reset_done_in  input  1  RX reset done (async, synchronized).
- rx_aligned_in  input  1  RX byte-aligned and error-free level from RX-domain monitor (async, synchronized).
- reset_all_out  output  1  to transceiver reset-all.
- tx_reset_datapath_out  output  1  to TX datapath reset.
- rx_reset_datapath_out  output  1  to RX datapath reset.
- tx_elecidle_out  output  1  to TX electrical idle.
- link_up_out  output  1  high only in LINK_UP.
- fault_out  output  1  high only in FAULT.
- retry_cnt_out  output  8  failed bring-ups since reset/restart.
- state_out  output  4  current state encoding.

## Operation
- All four status inputs pass through 2-flop synchronizers; FSM sees only synchronized values.
- States (state_out): RESET_ALL=0, WAIT_TX_CLK=1, WAIT_TX_DONE=2, WAIT_RX_DONE=3, WAIT_ALIGN=4, LINK_UP=5, TX_RESET=6, RX_RESET=7, BACKOFF=8, FAULT=9.
- Shared counter cleared on every state entry; counts clocks in state.
- RESET_ALL: reset_all_out=1 for RESET_CYCLES clocks -> WAIT_TX_CLK.
- WAIT_TX_CLK: tx_usrclk_active high -> WAIT_TX_DONE.
- WAIT_TX_DONE: tx_reset_done high -> WAIT_RX_DONE.
- WAIT_RX_DONE: rx_reset_done high -> WAIT_ALIGN.
- WAIT_ALIGN: separate alignment counter increments while rx_aligned high and clears to 0 when it is low; reaching ALIGN_CYCLES -> LINK_UP.
- Any WAIT_* state after TIMEOUT_CYCLES clocks without exit condition -> BACKOFF. If the exit condition and the timeout occur in the same clock, the exit condition wins.
- BACKOFF (1 clock): retry_cnt += 1 (saturating at 255). New count ≥ MAX_RETRIES -> FAULT, else -> RESET_ALL.
- LINK_UP: if tx_reset_done low -> TX_RESET; else if rx_reset_done or rx_aligned low -> RX_RESET (TX has priority); see Configuration.
- TX_RESET: tx_reset_datapath_out=1 for RESET_CYCLES -> WAIT_TX_DONE.
- RX_RESET: rx_reset_datapath_out=1 for RESET_CYCLES -> WAIT_RX_DONE.
- FAULT: holds until restart_in=1 -> retry_cnt=0, RESET_ALL.
- tx_elecidle_out=1 in RESET_ALL, WAIT_TX_CLK, WAIT_TX_DONE, TX_RESET, FAULT, BACKOFF; 0 otherwise.
- retry_cnt is not cleared on reaching LINK_UP.

## Timing
- All outputs registered and decoded from next state, so they change in the same clock the state changes.
- Reset values: state RESET_ALL, reset_all_out=1, tx/rx datapath resets 0, tx_elecidle_out=1, link_up_out=0, fault_out=0, retry_cnt_out=0, state_out=0. RESET_CYCLES count starts at the first clock after reset release.
- Input-to-FSM latency: 2 clocks of synchronizer, plus 1 clock for the transition.
- Reset pulse widths: exactly RESET_CYCLES clocks.
- Minimum WAIT_ALIGN dwell: ALIGN_CYCLES clocks. A single-clock drop restarts the alignment count.
- reset_n_in asserted mid-sequence returns the block to reset values immediately (asynchronous), including the synchronizers.

## Configuration
- HSSL_SEQ_AUTO_RECOVER_EN defined: loss of link in LINK_UP enters TX_RESET or RX_RESET as described.
- HSSL_SEQ_AUTO_RECOVER_EN undefined: any loss condition in LINK_UP -> FAULT directly. Retry count unchanged. TX_RESET/RX_RESET are unreachable and may be removed.

## Test plan
Bench parameters: RESET_CYCLES=4, TIMEOUT_CYCLES=64, ALIGN_CYCLES=8, MAX_RETRIES=3.
- Nominal: all inputs high after reset release -> reset_all_out high for exactly 4 clocks, then states 1→2→3→4, link_up_out rises 8 clocks after entering WAIT_ALIGN, tx_elecidle_out=0, retry_cnt_out=0.
- Align glitch: rx_aligned_in low for 1 clock after 5 clocks in WAIT_ALIGN -> link_up delayed so it occurs 8 clocks after rx_aligned_in returns high (plus sync latency).
- Timeouts: tx_usrclk_active_in held low -> BACKOFF every 64+4+1 clocks, retry_cnt 1,2,3, then fault_out=1 and state_out=9. A restart_in pulse -> retry_cnt_out=0, state 0.
- Recovery (macro defined): in LINK_UP drop rx_aligned_in -> link_up_out falls, rx_reset_datapath_out high for 4 clocks, relink via states 3, 4, 5. Drop tx_reset_done_in and rx_aligned_in together -> TX_RESET is taken.
- Macro undefined: same drop -> state 9, fault_out=1, no datapath reset pulse.
- Async reset asserted during TX_RESET -> all outputs at reset values within the same clock, with no clock edge required.
